// File: rtl/cd_bcd7seg_pkg.sv
// Shared constants for the multiplexed BCD/hex seven-segment scanner.
// Holds the active-high abcdefg glyph table and the digit-index width helper.
// Optional leading-zero blanking in the top is enabled by CD_BCD7SEG_LZB_EN.
package cd_bcd7seg_pkg;

    // Bit order {a,b,c,d,e,f,g}, active-high, indexed by the 4-bit code.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Width of the digit index: log2(N_DIGITS), at least one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cd_bcd7seg_dec.sv
// Nibble to seven-segment decoder, active-high abcdefg.
// Ports: nib_i (4-bit code), seg_o (7-bit segments, seg_o[6]=a).
module cd_bcd7seg_dec
    import cd_bcd7seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_LUT[nib_i];

endmodule

// File: rtl/cd_bcd7seg_scan.sv
// Multiplexed seven-segment scanner with frame-atomic display updates.
// Ports: clk, rst_n (async, active-low), load/bcd_in/dp_in/ready (value
// handshake), seg/dp/an (registered display drive, polarity per ACTIVE_LOW).
// Optional: CD_BCD7SEG_LZB_EN blanks leading zero digits above digit 0.
module cd_bcd7seg_scan
    import cd_bcd7seg_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    output logic                  ready,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an
);

    localparam int   IW  = idx_w(N_DIGITS);
    localparam int   PW  = $clog2(REFRESH_DIV);
    localparam logic INV = (ACTIVE_LOW != 0);

    logic [PW-1:0]         cnt_q;
    logic [IW-1:0]         idx_q;
    logic [4*N_DIGITS-1:0] pend_bcd_q, disp_bcd_q;
    logic [N_DIGITS-1:0]   pend_dp_q, disp_dp_q;
    logic                  ready_q;

    logic                  tick_q;
    logic [IW-1:0]         slot_q;
    logic [3:0]            nib_q;
    logic                  pdp_q;

    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [N_DIGITS-1:0]   an_q;

    logic                  tick, last, frame;
    logic [3:0]            nib_d;
    logic [6:0]            dec_seg, seg_d;
    logic [N_DIGITS-1:0]   an_d;

    assign tick  = (cnt_q == PW'(REFRESH_DIV - 1));
    assign last  = (idx_q == IW'(N_DIGITS - 1));
    assign frame = tick & last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
            idx_q <= last ? '0 : idx_q + IW'(1);
        end else begin
            cnt_q <= cnt_q + PW'(1);
        end
    end

    // Accept and commit are mutually exclusive through ready_q, so a load
    // landing on a frame boundary only fills pending and waits a full frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_bcd_q <= '0;
            pend_dp_q  <= '0;
            disp_bcd_q <= '0;
            disp_dp_q  <= '0;
            ready_q    <= 1'b1;
        end else if (load && ready_q) begin
            pend_bcd_q <= bcd_in;
            pend_dp_q  <= dp_in;
            ready_q    <= 1'b0;
        end else if (frame && !ready_q) begin
            disp_bcd_q <= pend_bcd_q;
            disp_dp_q  <= pend_dp_q;
            ready_q    <= 1'b1;
        end
    end

    assign nib_d = disp_bcd_q[4*int'(idx_q) +: 4];

    // The slot's digit is captured from the display register at the tick,
    // before a same-edge commit can change it; the output stage follows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
            slot_q <= '0;
            nib_q  <= '0;
            pdp_q  <= 1'b0;
        end else begin
            tick_q <= tick;
            if (tick) begin
                slot_q <= idx_q;
                nib_q  <= nib_d;
                pdp_q  <= disp_dp_q[idx_q];
            end
        end
    end

    cd_bcd7seg_dec u_dec (
        .nib_i (nib_q),
        .seg_o (dec_seg)
    );

`ifdef CD_BCD7SEG_LZB_EN
    logic hi_nz, blank_d, blank_q;

    // Blank when this digit and every digit above it are zero.
    always_comb begin
        hi_nz = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (k >= int'(idx_q) && disp_bcd_q[4*k +: 4] != 4'd0) begin
                hi_nz = 1'b1;
            end
        end
        blank_d = (idx_q != '0) && !hi_nz;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= 1'b0;
        end else if (tick) begin
            blank_q <= blank_d;
        end
    end

    assign seg_d = blank_q ? 7'b0000000 : dec_seg;
`else
    assign seg_d = dec_seg;
`endif

    assign an_d = N_DIGITS'(1) << slot_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= {7{INV}};
            dp_q  <= INV;
            an_q  <= {N_DIGITS{INV}};
        end else if (tick_q) begin
            seg_q <= seg_d ^ {7{INV}};
            dp_q  <= pdp_q ^ INV;
            an_q  <= an_d ^ {N_DIGITS{INV}};
        end
    end

    assign ready = ready_q;
    assign seg   = seg_q;
    assign dp    = dp_q;
    assign an    = an_q;

endmodule

// File: tb/tb_cd_bcd7seg_scan.sv
// Self-checking bench for cd_bcd7seg_scan (N_DIGITS=4, REFRESH_DIV=4,
// ACTIVE_LOW=1); honours CD_BCD7SEG_LZB_EN for the blanking vectors.
module tb_cd_bcd7seg_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic        ready;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int checks = 0;
    int failures = 0;

    cd_bcd7seg_scan #(
        .N_DIGITS    (4),
        .REFRESH_DIV (4),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .bcd_in (bcd_in),
        .dp_in  (dp_in),
        .ready  (ready),
        .seg    (seg),
        .dp     (dp),
        .an     (an)
    );

    always #5 clk = ~clk;

    // Reference model state: n counts rising edges since reset release.
    int          n;
    logic        m_ready;
    logic [15:0] m_pbcd, m_dbcd, m_prev_bcd;
    logic [3:0]  m_pdp, m_ddp, m_prev_dp;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;

    typedef struct {
        logic [15:0]      bcd;
        logic [3:0]       dpv;
        logic [3:0][6:0]  s;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    function automatic logic ref_blank(input logic [15:0] b, input int d);
`ifdef CD_BCD7SEG_LZB_EN
        return (d > 0) && ((b >> (4 * d)) == 16'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        n = 0;
        m_ready = 1'b1;
        m_pbcd = '0; m_dbcd = '0; m_prev_bcd = '0;
        m_pdp = '0; m_ddp = '0; m_prev_dp = '0;
        e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
    endtask

    // Ticks fall on edges 4,8,12,...; the digit for the slot starting at
    // tick edge t appears at edge t+1, showing the value displayed before t.
    // Frames end on edges that are multiples of 16.
    task automatic model_edge();
        int d;
        n++;
        if (n >= 5 && (n - 5) % 4 == 0) begin
            d = ((n - 5) / 4) % 4;
            e_an  = ~(4'd1 << d);
            e_seg = ref_blank(m_prev_bcd, d) ? 7'h7F
                  : ~ref_seg(m_prev_bcd[4*d +: 4]);
            e_dp  = ~m_prev_dp[d];
        end
        m_prev_bcd = m_dbcd;
        m_prev_dp  = m_ddp;
        if (load && m_ready) begin
            m_pbcd = bcd_in;
            m_pdp  = dp_in;
            m_ready = 1'b0;
        end else if (n % 16 == 0 && !m_ready) begin
            m_dbcd = m_pbcd;
            m_ddp  = m_pdp;
            m_ready = 1'b1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model", {19'd0, ready, an, seg, dp},
            {19'd0, m_ready, e_an, e_seg, e_dp});
    endtask

    task automatic wait_ready(input logic v);
        int k;
        k = 0;
        while (ready !== v && k < 64) begin
            step();
            k++;
        end
        chk("ready_wait", {31'd0, ready}, {31'd0, v});
    endtask

    task automatic wait_an(input logic [3:0] v);
        int k;
        k = 0;
        while (an !== v && k < 40) begin
            step();
            k++;
        end
        chk("an_wait", {28'd0, an}, {28'd0, v});
    endtask

    task automatic do_load(input logic [15:0] b, input logic [3:0] d);
        wait_ready(1'b1);
        load = 1'b1;
        bcd_in = b;
        dp_in = d;
        step();
        load = 1'b0;
        chk("ready_drop", {31'd0, ready}, 32'd0);
    endtask

    task automatic check_frame(input int i);
        for (int d = 0; d < 4; d++) begin
            wait_an(~(4'd1 << d));
            chk("vec_seg", {25'd0, seg}, {25'd0, vecs[i].s[d]});
            chk("vec_dp", {31'd0, dp}, {31'd0, ~vecs[i].dpv[d]});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=done");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        vecs[0] = '{bcd: 16'h1234, dpv: 4'b0100,
                    s: {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}};
        vecs[1] = '{bcd: 16'h89AB, dpv: 4'b0001,
                    s: {7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000}};
        vecs[2] = '{bcd: 16'hCDEF, dpv: 4'b1010,
                    s: {7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000}};
        vecs[3] = '{bcd: 16'h5670, dpv: 4'b1111,
                    s: {7'b0100100, 7'b0100000, 7'b0001111, 7'b0000001}};
`ifdef CD_BCD7SEG_LZB_EN
        vecs[4] = '{bcd: 16'h0050, dpv: 4'b0000,
                    s: {7'b1111111, 7'b1111111, 7'b0100100, 7'b0000001}};
        vecs[5] = '{bcd: 16'h0000, dpv: 4'b1000,
                    s: {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}};
`else
        vecs[4] = '{bcd: 16'h0050, dpv: 4'b0000,
                    s: {7'b0000001, 7'b0000001, 7'b0100100, 7'b0000001}};
        vecs[5] = '{bcd: 16'h0000, dpv: 4'b1000,
                    s: {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}};
`endif

        model_reset();
        #12;
        chk("rst_out", {19'd0, ready, an, seg, dp},
            {19'd0, 1'b1, 4'hF, 7'h7F, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;

        repeat (4) step();
        chk("first_en_early", {28'd0, an}, {28'd0, 4'hF});
        step();
        chk("first_en", {28'd0, an}, {28'd0, 4'b1110});
        chk("first_seg", {25'd0, seg}, {25'd0, 7'b0000001});
        repeat (4) step();
        chk("second_en", {28'd0, an}, {28'd0, 4'b1101});

        for (int i = 0; i < 6; i++) begin
            do_load(vecs[i].bcd, vecs[i].dpv);
            wait_ready(1'b1);
            check_frame(i);
        end

        do_load(16'h1234, 4'b0100);
        bcd_in = 16'hFFFF;
        dp_in = 4'hF;
        repeat (3) begin
            load = (ready == 1'b0);
            step();
        end
        load = 1'b0;
        wait_ready(1'b1);
        check_frame(0);

        wait_ready(1'b1);
        while (n % 16 != 15) step();
        load = 1'b1;
        bcd_in = 16'h89AB;
        dp_in = 4'b0001;
        step();
        load = 1'b0;
        chk("coinc_ready", {31'd0, ready}, 32'd0);
        k = 0;
        while (ready !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        chk("coinc_delay", k, 16);
        check_frame(1);

        for (int c = 0; c < 500; c++) begin
            load = ($urandom_range(0, 3) == 0);
            bcd_in = 16'($urandom);
            dp_in = 4'($urandom);
            step();
        end
        load = 1'b0;

        do_load(16'h8888, 4'b1111);
        step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {19'd0, ready, an, seg, dp},
            {19'd0, 1'b1, 4'hF, 7'h7F, 1'b1});
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) step();
        wait_an(4'b1110);
        chk("rst_no_pend", {25'd0, seg}, {25'd0, 7'b0000001});
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
